// File: rtl/serial_word_tx.sv
// serial_word_tx: framed MSB-first parallel-to-serial transmitter.
// One-entry holding register in front of a shifter with sclk/cs_n framing.
module serial_word_tx #(
  parameter int DATLEN   = 12,
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATLEN-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sclk_out,
  output logic              sdata,
  output logic              cs_n,
  output logic              busy,
  output logic              frame_done
);

  localparam int PW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(DATLEN);
  localparam int GAPC = (GAP_BITS > 0) ? GAP_BITS * CLK_DIV : 1;
  localparam int GW   = $clog2(GAPC + 1);
  localparam bit HAS_GAP = (GAP_BITS > 0);

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH  = PW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATLEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAPC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t            state_q, state_n;
  logic [DATLEN-1:0] hold_q, hold_n;
  logic              full_q, full_n;
  logic [DATLEN-1:0] shreg_q, shreg_n;
  logic [PW-1:0]     ph_q, ph_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic [GW-1:0]     gap_q, gap_n;
  logic              sclk_q, sclk_n;
  logic              sdat_q, sdat_n;
  logic              cs_q, cs_n_n;
  logic              fd_q, fd_n;
  logic              busy_q, busy_n;

  logic              ph_wrap;
  logic              last_tick;
  logic              gap_end;
  logic              load_now;
  logic              accept;
  logic [PW-1:0]     ph_inc;

  assign din_ready  = ~full_q | load_now;
  assign sclk_out   = sclk_q;
  assign sdata      = sdat_q;
  assign cs_n       = cs_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

  // Next-state, shifter, framing and holding-register logic.
  always_comb begin
    ph_wrap   = (ph_q == PH_LAST);
    last_tick = (state_q == SHIFT) && ph_wrap && (bit_q == BIT_LAST);
    gap_end   = (state_q == GAP) && (gap_q == GAP_LAST);
    load_now  = full_q && ((state_q == IDLE) || gap_end ||
                           (last_tick && !HAS_GAP));
    accept    = din_valid && din_ready;
    ph_inc    = ph_q + 1'b1;

    state_n = state_q;
    hold_n  = hold_q;
    full_n  = full_q;
    shreg_n = shreg_q;
    ph_n    = ph_q;
    bit_n   = bit_q;
    gap_n   = gap_q;
    sclk_n  = sclk_q;
    sdat_n  = sdat_q;
    cs_n_n  = cs_q;
    fd_n    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cs_n_n = 1'b1;
        sclk_n = 1'b0;
        sdat_n = 1'b0;
      end
      SHIFT: begin
        if (ph_wrap) begin
          ph_n   = '0;
          sclk_n = 1'b0;
          if (bit_q == BIT_LAST) begin
            bit_n   = '0;
            cs_n_n  = 1'b1;
            sdat_n  = 1'b0;
            fd_n    = 1'b1;
            gap_n   = '0;
            state_n = HAS_GAP ? GAP : IDLE;
          end else begin
            bit_n   = bit_q + 1'b1;
            shreg_n = shreg_q << 1;
            sdat_n  = shreg_q[DATLEN-2];
          end
        end else begin
          ph_n   = ph_inc;
          sclk_n = (ph_inc >= PH_HIGH);
        end
      end
      GAP: begin
        if (gap_end) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load_now) begin
      state_n = SHIFT;
      shreg_n = hold_q;
      sdat_n  = hold_q[DATLEN-1];
      cs_n_n  = 1'b0;
      sclk_n  = 1'b0;
      ph_n    = '0;
      bit_n   = '0;
    end

    if (accept) begin
      hold_n = din;
      full_n = 1'b1;
    end else if (load_now) begin
      full_n = 1'b0;
    end

    busy_n = (state_n != IDLE) || full_n;
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      full_q  <= 1'b0;
      shreg_q <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      cs_q    <= 1'b1;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      full_q  <= full_n;
      shreg_q <= shreg_n;
      ph_q    <= ph_n;
      bit_q   <= bit_n;
      gap_q   <= gap_n;
      sclk_q  <= sclk_n;
      sdat_q  <= sdat_n;
      cs_q    <= cs_n_n;
      fd_q    <= fd_n;
      busy_q  <= busy_n;
    end
  end

endmodule
